// File: rtl/buf_tag_if.sv
// buf_tag_if: request/response, LFU finder and fill handshake bundle for buf_tag_ctrl.
interface buf_tag_if #(parameter int TAG_W = 8);
  logic             req_vld;
  logic [TAG_W-1:0] req_tag;
  logic             req_rdy;
  logic             resp_vld;
  logic             resp_hit;
  logic [1:0]       resp_buf_num;
  logic [1:0]       ref_buf_numbr;
  logic             ref_vld;
  logic             new_buf_req;
  logic [1:0]       buf_num_replc;
  logic             fill_req;
  logic [1:0]       fill_buf_num;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_done;
  modport master (
    output req_vld, req_tag, buf_num_replc, fill_done,
    input  req_rdy, resp_vld, resp_hit, resp_buf_num, ref_buf_numbr, ref_vld,
           new_buf_req, fill_req, fill_buf_num, fill_tag
  );
  modport slave (
    input  req_vld, req_tag, buf_num_replc, fill_done,
    output req_rdy, resp_vld, resp_hit, resp_buf_num, ref_buf_numbr, ref_vld,
           new_buf_req, fill_req, fill_buf_num, fill_tag
  );
endinterface

// File: rtl/buf_tag_ctrl.sv
// buf_tag_ctrl: tag lookup for a 4-entry LFU buffer pool with victim request and fill handshake.
module buf_tag_ctrl #(
  parameter int TAG_W   = 8,
  parameter int NUM_BUF = 4
) (
  input logic     clk,
  input logic     rst_n,
  buf_tag_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMP, VICT, FILL} state_t;
  state_t             r_state, w_next;
  logic [TAG_W-1:0]   r_tag;
  logic [TAG_W-1:0]   r_tags [NUM_BUF];
  logic [NUM_BUF-1:0] r_vld;
  logic [1:0]         r_fill_buf, r_resp_buf, r_ref_buf;
  logic               r_resp_vld, r_resp_hit, r_ref_vld, r_new_buf_req;
  logic               w_hit, w_free;
  logic [1:0]         w_hit_idx, w_free_idx;
  // descending scan so the lowest-index free entry wins
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if (r_vld[i] && r_tags[i] == r_tag) begin
        w_hit     = 1'b1;
        w_hit_idx = 2'(i);
      end
      if (!r_vld[i]) begin
        w_free     = 1'b1;
        w_free_idx = 2'(i);
      end
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = bus.req_vld ? CMP : IDLE;
      CMP:     w_next = w_hit ? IDLE : (w_free ? FILL : VICT);
      VICT:    w_next = FILL;
      FILL:    w_next = bus.fill_done ? IDLE : FILL;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag         <= '0;
      r_vld         <= '0;
      r_fill_buf    <= '0;
      r_resp_buf    <= '0;
      r_ref_buf     <= '0;
      r_resp_vld    <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_ref_vld     <= 1'b0;
      r_new_buf_req <= 1'b0;
      for (int i = 0; i < NUM_BUF; i++) r_tags[i] <= '0;
    end else begin
      r_resp_vld    <= 1'b0;
      r_ref_vld     <= 1'b0;
      r_new_buf_req <= 1'b0;
      if (r_state == IDLE && bus.req_vld) r_tag <= bus.req_tag;
      if (r_state == CMP) begin
        if (w_hit) begin
          r_resp_vld <= 1'b1;
          r_resp_hit <= 1'b1;
          r_resp_buf <= w_hit_idx;
          r_ref_buf  <= w_hit_idx;
          r_ref_vld  <= 1'b1;
        end else if (w_free) r_fill_buf <= w_free_idx;
        else r_new_buf_req <= 1'b1;
      end
      if (r_state == VICT) begin
        r_fill_buf               <= bus.buf_num_replc;
        r_vld[bus.buf_num_replc] <= 1'b0;
      end
      if (r_state == FILL && bus.fill_done) begin
        r_tags[r_fill_buf] <= r_tag;
        r_vld[r_fill_buf]  <= 1'b1;
        r_resp_vld         <= 1'b1;
        r_resp_hit         <= 1'b0;
        r_resp_buf         <= r_fill_buf;
        r_ref_buf          <= r_fill_buf;
        r_ref_vld          <= 1'b1;
      end
    end
  end
  assign bus.req_rdy       = r_state == IDLE;
  assign bus.fill_req      = r_state == FILL;
  assign bus.fill_buf_num  = r_fill_buf;
  assign bus.fill_tag      = r_tag;
  assign bus.resp_vld      = r_resp_vld;
  assign bus.resp_hit      = r_resp_hit;
  assign bus.resp_buf_num  = r_resp_buf;
  assign bus.ref_buf_numbr = r_ref_buf;
  assign bus.ref_vld       = r_ref_vld;
  assign bus.new_buf_req   = r_new_buf_req;
endmodule

// File: tb/tb_buf_tag_ctrl.sv
// tb_buf_tag_ctrl: directed scenarios for buf_tag_ctrl, stimulus and sampling on the falling edge.
module tb_buf_tag_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int nb_cnt = 0;
  buf_tag_if #(.TAG_W(8)) bus();
  buf_tag_ctrl #(.TAG_W(8), .NUM_BUF(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.new_buf_req === 1'b1) nb_cnt++;
  task automatic send(input logic [7:0] t);
    bus.req_vld = 1'b1;
    bus.req_tag = t;
    @(negedge clk);
    bus.req_vld = 1'b0;
  endtask
  task automatic test_reset;
    bus.req_vld = 1'b0;
    bus.req_tag = '0;
    bus.fill_done = 1'b0;
    bus.buf_num_replc = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.req_rdy, bus.resp_vld, bus.resp_hit, bus.ref_vld, bus.new_buf_req, bus.fill_req} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=100000", {bus.req_rdy, bus.resp_vld, bus.resp_hit, bus.ref_vld, bus.new_buf_req, bus.fill_req});
    end
    checks++;
    if ({bus.resp_buf_num, bus.ref_buf_numbr, bus.fill_buf_num, bus.fill_tag} !== 14'd0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {bus.resp_buf_num, bus.ref_buf_numbr, bus.fill_buf_num, bus.fill_tag});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_fill_empty;
    int nb0;
    logic [7:0] t;
    nb0 = nb_cnt;
    for (int i = 0; i < 4; i++) begin
      t = 8'((i + 1) * 16);
      checks++;
      if (bus.req_rdy !== 1'b1) begin
        failures++;
        $display("FAIL fill_rdy i=%0d got=%b exp=1", i, bus.req_rdy);
      end
      send(t);
      @(negedge clk);
      checks++;
      if ({bus.fill_req, bus.fill_buf_num, bus.fill_tag, bus.resp_vld} !== {1'b1, 2'(i), t, 1'b0}) begin
        failures++;
        $display("FAIL fill_start i=%0d got=%h exp=%h", i, {bus.fill_req, bus.fill_buf_num, bus.fill_tag, bus.resp_vld}, {1'b1, 2'(i), t, 1'b0});
      end
      @(negedge clk);
      bus.fill_done = 1'b1;
      @(negedge clk);
      bus.fill_done = 1'b0;
      checks++;
      if ({bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req} !== {1'b1, 1'b0, 2'(i), 1'b1, 2'(i), 1'b0}) begin
        failures++;
        $display("FAIL fill_resp i=%0d got=%b exp=%b", i, {bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req}, {1'b1, 1'b0, 2'(i), 1'b1, 2'(i), 1'b0});
      end
      @(negedge clk);
      checks++;
      if ({bus.resp_vld, bus.ref_vld} !== 2'b00) begin
        failures++;
        $display("FAIL fill_pulse i=%0d got=%b exp=00", i, {bus.resp_vld, bus.ref_vld});
      end
    end
    checks++;
    if (nb_cnt !== nb0) begin
      failures++;
      $display("FAIL fill_no_victim got=%0d exp=%0d", nb_cnt, nb0);
    end
  endtask
  task automatic test_hit;
    send(8'h30);
    checks++;
    if ({bus.resp_vld, bus.fill_req} !== 2'b00) begin
      failures++;
      $display("FAIL hit_early got=%b exp=00", {bus.resp_vld, bus.fill_req});
    end
    @(negedge clk);
    checks++;
    if ({bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req} !== 8'b11_10_1_10_0) begin
      failures++;
      $display("FAIL hit_resp got=%b exp=11101100", {bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req});
    end
    @(negedge clk);
    checks++;
    if ({bus.resp_vld, bus.ref_vld, bus.fill_req} !== 3'b000) begin
      failures++;
      $display("FAIL hit_pulse got=%b exp=000", {bus.resp_vld, bus.ref_vld, bus.fill_req});
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] tg [3] = '{8'h10, 8'h10, 8'h40};
    logic [1:0] bn [3] = '{2'd0, 2'd0, 2'd3};
    int nb0;
    nb0 = nb_cnt;
    for (int i = 0; i < 3; i++) begin
      send(tg[i]);
      checks++;
      if ({bus.resp_vld, bus.ref_vld} !== 2'b00) begin
        failures++;
        $display("FAIL b2b_gap i=%0d got=%b exp=00", i, {bus.resp_vld, bus.ref_vld});
      end
      @(negedge clk);
      checks++;
      if ({bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.req_rdy} !== {2'b11, bn[i], 1'b1, bn[i], 1'b1}) begin
        failures++;
        $display("FAIL b2b_resp i=%0d got=%b exp=%b", i, {bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.req_rdy}, {2'b11, bn[i], 1'b1, bn[i], 1'b1});
      end
    end
    @(negedge clk);
    checks++;
    if (nb_cnt !== nb0) begin
      failures++;
      $display("FAIL b2b_no_victim got=%0d exp=%0d", nb_cnt, nb0);
    end
  endtask
  task automatic test_victim;
    int nb0;
    nb0 = nb_cnt;
    bus.buf_num_replc = 2'd1;
    send(8'h55);
    checks++;
    if (bus.new_buf_req !== 1'b0) begin
      failures++;
      $display("FAIL vict_cmp got=%b exp=0", bus.new_buf_req);
    end
    @(negedge clk);
    checks++;
    if ({bus.new_buf_req, bus.fill_req} !== 2'b10) begin
      failures++;
      $display("FAIL vict_req got=%b exp=10", {bus.new_buf_req, bus.fill_req});
    end
    @(negedge clk);
    bus.buf_num_replc = 2'd3;
    checks++;
    if ({bus.new_buf_req, bus.fill_req, bus.fill_buf_num, bus.fill_tag} !== {2'b01, 2'd1, 8'h55}) begin
      failures++;
      $display("FAIL vict_fill got=%h exp=%h", {bus.new_buf_req, bus.fill_req, bus.fill_buf_num, bus.fill_tag}, {2'b01, 2'd1, 8'h55});
    end
    @(negedge clk);
    checks++;
    if ({bus.fill_req, bus.fill_buf_num, bus.fill_tag} !== {1'b1, 2'd1, 8'h55}) begin
      failures++;
      $display("FAIL vict_stable got=%h exp=%h", {bus.fill_req, bus.fill_buf_num, bus.fill_tag}, {1'b1, 2'd1, 8'h55});
    end
    bus.fill_done = 1'b1;
    @(negedge clk);
    bus.fill_done = 1'b0;
    checks++;
    if ({bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req} !== 8'b10_01_1_01_0) begin
      failures++;
      $display("FAIL vict_resp got=%b exp=10011010", {bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req});
    end
    checks++;
    if (nb_cnt !== nb0 + 1) begin
      failures++;
      $display("FAIL vict_pulse_count got=%0d exp=%0d", nb_cnt, nb0 + 1);
    end
    @(negedge clk);
    bus.buf_num_replc = 2'd2;
    send(8'h20);
    @(negedge clk);
    checks++;
    if (bus.new_buf_req !== 1'b1) begin
      failures++;
      $display("FAIL evicted_miss got=%b exp=1", bus.new_buf_req);
    end
    @(negedge clk);
    bus.fill_done = 1'b1;
    checks++;
    if ({bus.fill_req, bus.fill_buf_num, bus.fill_tag} !== {1'b1, 2'd2, 8'h20}) begin
      failures++;
      $display("FAIL evicted_fill got=%h exp=%h", {bus.fill_req, bus.fill_buf_num, bus.fill_tag}, {1'b1, 2'd2, 8'h20});
    end
    @(negedge clk);
    bus.fill_done = 1'b0;
    checks++;
    if ({bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req} !== 8'b10_10_1_10_0) begin
      failures++;
      $display("FAIL fast_fill_resp got=%b exp=10101100", {bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req});
    end
    @(negedge clk);
    send(8'h55);
    @(negedge clk);
    checks++;
    if ({bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req} !== 8'b11_01_1_01_0) begin
      failures++;
      $display("FAIL victim_hit got=%b exp=11011010", {bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req});
    end
    @(negedge clk);
  endtask
  task automatic test_slow_fill;
    bus.buf_num_replc = 2'd3;
    bus.req_vld = 1'b1;
    bus.req_tag = 8'h66;
    @(negedge clk);
    bus.fill_done = 1'b1;
    checks++;
    if (bus.req_rdy !== 1'b0) begin
      failures++;
      $display("FAIL slow_rdy_cmp got=%b exp=0", bus.req_rdy);
    end
    @(negedge clk);
    bus.fill_done = 1'b0;
    checks++;
    if ({bus.req_rdy, bus.new_buf_req, bus.fill_req} !== 3'b010) begin
      failures++;
      $display("FAIL slow_vict got=%b exp=010", {bus.req_rdy, bus.new_buf_req, bus.fill_req});
    end
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.req_rdy, bus.fill_req, bus.fill_buf_num, bus.fill_tag, bus.resp_vld} !== {2'b01, 2'd3, 8'h66, 1'b0}) begin
        failures++;
        $display("FAIL slow_hold k=%0d got=%h exp=%h", k, {bus.req_rdy, bus.fill_req, bus.fill_buf_num, bus.fill_tag, bus.resp_vld}, {2'b01, 2'd3, 8'h66, 1'b0});
      end
      @(negedge clk);
    end
    bus.fill_done = 1'b1;
    @(negedge clk);
    bus.fill_done = 1'b0;
    checks++;
    if ({bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.req_rdy} !== 8'b10_11_1_11_1) begin
      failures++;
      $display("FAIL slow_resp got=%b exp=10111111", {bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.req_rdy});
    end
    @(negedge clk);
    bus.req_vld = 1'b0;
    checks++;
    if ({bus.req_rdy, bus.resp_vld} !== 2'b00) begin
      failures++;
      $display("FAIL slow_reaccept got=%b exp=00", {bus.req_rdy, bus.resp_vld});
    end
    @(negedge clk);
    checks++;
    if ({bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req} !== 8'b11_11_1_11_0) begin
      failures++;
      $display("FAIL slow_held_hit got=%b exp=11111110", {bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req});
    end
    @(negedge clk);
  endtask
  task automatic test_reset_mid_fill;
    int nb0;
    bus.buf_num_replc = 2'd2;
    send(8'h77);
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.fill_req, bus.fill_buf_num} !== 3'b110) begin
      failures++;
      $display("FAIL rst_pre_fill got=%b exp=110", {bus.fill_req, bus.fill_buf_num});
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({bus.fill_req, bus.req_rdy, bus.resp_vld, bus.ref_vld, bus.new_buf_req, bus.resp_hit} !== 6'b010000) begin
      failures++;
      $display("FAIL rst_mid_ctrl got=%b exp=010000", {bus.fill_req, bus.req_rdy, bus.resp_vld, bus.ref_vld, bus.new_buf_req, bus.resp_hit});
    end
    checks++;
    if ({bus.resp_buf_num, bus.ref_buf_numbr, bus.fill_buf_num, bus.fill_tag} !== 14'd0) begin
      failures++;
      $display("FAIL rst_mid_data got=%h exp=0", {bus.resp_buf_num, bus.ref_buf_numbr, bus.fill_buf_num, bus.fill_tag});
    end
    nb0 = nb_cnt;
    send(8'h10);
    @(negedge clk);
    bus.fill_done = 1'b1;
    checks++;
    if ({bus.new_buf_req, bus.fill_req, bus.fill_buf_num, bus.fill_tag} !== {2'b01, 2'd0, 8'h10}) begin
      failures++;
      $display("FAIL rst_refill got=%h exp=%h", {bus.new_buf_req, bus.fill_req, bus.fill_buf_num, bus.fill_tag}, {2'b01, 2'd0, 8'h10});
    end
    @(negedge clk);
    bus.fill_done = 1'b0;
    checks++;
    if ({bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req} !== 8'b10_00_1_00_0) begin
      failures++;
      $display("FAIL rst_refill_resp got=%b exp=10001000", {bus.resp_vld, bus.resp_hit, bus.resp_buf_num, bus.ref_vld, bus.ref_buf_numbr, bus.fill_req});
    end
    checks++;
    if (nb_cnt !== nb0) begin
      failures++;
      $display("FAIL rst_no_victim got=%0d exp=%0d", nb_cnt, nb0);
    end
    @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_fill_empty();
    test_hit();
    test_back_to_back();
    test_victim();
    test_slow_fill();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/buf_tag_ctrl.md
Name: buf_tag_ctrl

Overview:
- Upstream control stage for the 4-entry LFU buffer pool.
- Holds one tag plus a valid bit per buffer and looks up each incoming request.
- Reports every reference to the LFU finder through ref_buf_numbr/ref_vld.
- On a miss with all buffers valid, pulses new_buf_req, takes the victim from buf_num_replc, and runs a fill handshake before writing the new tag.

Parameters:
TAG_W, 8, width of request tag
NUM_BUF, 4, buffer count; fixed at 4 to match the 2-bit buffer numbering

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_vld  in  1  request valid
req_tag  in  TAG_W  requested tag
req_rdy  out  1  request accepted when req_vld && req_rdy at clk edge
resp_vld  out  1  one-cycle response pulse
resp_hit  out  1  1 = hit, 0 = miss serviced; qualified by resp_vld
resp_buf_num  out  2  buffer holding the tag; qualified by resp_vld
ref_buf_numbr  out  2  referenced buffer to LFU finder; holds last value
ref_vld  out  1  one-cycle pulse, one per serviced request
new_buf_req  out  1  one-cycle victim request to LFU finder
buf_num_replc  in  2  victim buffer from LFU finder
fill_req  out  1  fill request to backing store, level until fill_done
fill_buf_num  out  2  buffer being filled
fill_tag  out  TAG_W  tag being filled
fill_done  in  1  fill complete; sampled only while fill_req=1

Behaviour:
- Reset (rst_n=0 at edge):
  - state=IDLE and all valid bits cleared.
  - req_rdy=1.
  - resp_vld, resp_hit, ref_vld, new_buf_req, fill_req = 0.
  - resp_buf_num, ref_buf_numbr, fill_buf_num = 0; fill_tag = 0.
  - Reset mid-operation aborts it; fill_req drops at that edge.
- State IDLE (req_rdy=1):
  - On accept, latch req_tag, then go to CMP. req_rdy is 0 in every state other than IDLE.
- State CMP (1 cycle): compare the latched tag against all valid entries.
  - Hit on entry k: next edge sets resp_vld=1, resp_hit=1, resp_buf_num=k, ref_buf_numbr=k, ref_vld=1; go to IDLE. Request-to-response latency is 2 cycles.
  - Miss with an invalid entry: pick the lowest-index invalid entry, go to FILL. new_buf_req is not asserted.
  - Miss with all 4 entries valid: new_buf_req=1 for one cycle, go to VICT.
- State VICT (1 cycle): the LFU finder output settles.
  - At the end of VICT, sample buf_num_replc as the victim. Clear that entry's valid bit. Go to FILL.
- State FILL:
  - fill_req=1, with fill_buf_num and fill_tag stable for the whole state.
  - On fill_done=1 at an edge: write the tag and set valid. Drop fill_req.
  - At the same edge: resp_vld=1, resp_hit=0, resp_buf_num = filled buffer, ref_buf_numbr = filled buffer, ref_vld=1. Go to IDLE.
  - fill_done is allowed in the first FILL cycle; minimum fill length is 1 cycle. There is no timeout.
- Pulses: resp_vld, ref_vld and new_buf_req are high for exactly one cycle.
- Tag uniqueness: a tag is never resident in two entries, so at most one CMP match.
- Back-to-back: the earliest next accept is the cycle after resp_vld, since IDLE re-asserts req_rdy.
- Ignored inputs: fill_done outside FILL is ignored; req_vld outside IDLE is ignored (no accept).
- buf_num_replc is sampled only at the end of VICT.

Test Plan:
1. Reset, then requests with tags 0x10, 0x20, 0x30, 0x40, fill_done one cycle after fill_req each time -> fills go to buffers 0, 1, 2, 3. No new_buf_req. Each response has resp_hit=0 and ref_buf_numbr=0, 1, 2, 3 respectively.
2. After case 1, request 0x30 -> resp_vld 2 cycles after accept, resp_hit=1, resp_buf_num=2, ref_vld pulse with ref_buf_numbr=2, fill_req stays 0.
3. After case 1, request 0x55 with buf_num_replc=1 -> new_buf_req one-cycle pulse, then fill_req with fill_buf_num=1 and fill_tag=0x55. After fill_done, resp_hit=0 and resp_buf_num=1. A following request for 0x20 misses; a request for 0x55 hits buffer 1.
4. Delay fill_done by 5 cycles while holding req_vld=1 with tag 0x66 -> req_rdy=0 throughout, fill outputs stable. 0x66 is accepted only after the response.
5. Assert rst_n=0 during FILL -> fill_req=0 and req_rdy=1 after the edge. A request for 0x10 then misses and fills buffer 0 with no new_buf_req.
6. Back-to-back hits on 0x10, 0x10, 0x40 -> resp_buf_num 0, 0, 3, each at 2-cycle latency with consecutive ref_vld pulses. new_buf_req never asserted.
